fir_fold_sched: RTL and testbench
=================================

# fir_fold_sched

Time-multiplexed (folded) scheduler for the 8th-order, 11-bit-coefficient FIR. One signed 11x11 multiplier and one accumulator are shared across all nine taps: one tap is sequenced per clock. A circular 9-entry sample buffer replaces the parallel delay line. It sits between the sample source (data generator / upstream stream) and the data sink, and uses a VIN/READY input handshake because it accepts at most one sample every 10 cycles.

## Interface
- No parameters: 11-bit data, 11-bit coefficients, 9 taps, 26-bit accumulator are fixed.
- CLK  in  1  single clock, all state updates on rising edge.
- RST_n  in  1  reset; synchronous and active-low.
- DIN  in  11  input sample, signed two's complement.
- VIN  in  1  DIN valid.
- READY  out  1  block can accept a sample this cycle.
- H0..H8  in  11 each  coefficients, signed Q1.10 (1024 = 1.0).
- DOUT  out  11  filtered sample, signed, registered.
- VOUT  out  1  DOUT valid, one-cycle pulse per accepted sample.

## Operation
- States: IDLE (READY=1), MAC (READY=0).
- Accept: rising edge with VIN=1 and READY=1.
  - DIN is written to buf[wptr], and wptr advances 0..8 with wrap 8->0.
  - H0..H8 are copied into shadow registers.
  - acc <= 0, tap <= 0, state <= MAC.
- VIN while READY=0 is ignored; the sample is not stored and no error flag is raised.
- MAC, one tap per edge:
  - acc <= acc + Hs[tap] * buf[(newest - tap) mod 9].
  - The product is a full-precision 22-bit signed value, sign-extended to 26 bits.
  - tap increments 0..8.
- Final MAC edge (tap=8):
  - DOUT <= (acc + product)[20:10]: arithmetic floor by 2^10, no rounding, no saturation (wraps to 11 bits).
  - VOUT <= 1, READY <= 1, state <= IDLE.
- Any other edge: VOUT <= 0.
- Samples not yet received since reset read as 0 (buffer cleared by reset).
- Coefficient input changes after the accept edge do not affect the current output; they apply from the next accept.

## Timing
- Reset (RST_n=0 at an edge):
  - state=IDLE, buf all 0, wptr=0, acc=0, tap=0, shadow coefficients 0.
  - DOUT=0, VOUT=0, READY=0.
  - READY goes 1 on the first edge with RST_n=1.
- Reset mid-MAC aborts the computation. No VOUT is produced for that sample and the buffer is cleared.
- Latency: accept edge E0. MAC edges E1..E9. VOUT=1 and DOUT valid from E9 to E10.
- READY rises at E9, together with VOUT. A sample presented with VIN=1 in that cycle is accepted at E10.
- Maximum throughput: one sample per 10 cycles. With VIN held high, accepts occur at E0, E10, E20... and VOUT pulses at E9, E19...
- DOUT holds its value between VOUT pulses.
- Simultaneous VIN and RST_n=0: reset wins, and the sample is dropped.

## Test plan
- Impulse, H_k=64*(k+1):
  - Stimulus: DIN=1023, then 9 samples of 0.
  - Required DOUT sequence: 63, 127, 191, 255, 319, 383, 447, 511, 575, then 0.
  - Each output comes with exactly one VOUT pulse, 9 cycles after its accept.
- Sign and floor, H0=1023 and others 0:
  - Stimulus: DIN=-1024.
  - Required: DOUT=-1023 (11'h401).
  - Then DIN=1: required DOUT=0 (floor of 1023/1024).
- Wrap, all H=1023:
  - Stimulus: DIN=1023 repeated.
  - Required: the 9th and all later outputs are DOUT=1006 (9418761 >> 10 = 9198, wrapped to 11 bits). Earlier outputs are k*1046529 >> 10 wrapped.
- Back-to-back, VIN held high:
  - Required: READY low for 9 cycles after each accept.
  - Required: accepts every 10 cycles, VOUT period 10, no sample skipped or duplicated, verified against the C golden model file.
- Coefficient hold:
  - Stimulus: change all H to 0 on E3 of a MAC run.
  - Required: the current DOUT equals the value computed with the old coefficients; the next output uses 0.
- Reset mid-operation:
  - Stimulus: RST_n=0 for one edge at E5.
  - Required: no VOUT for that sample, DOUT=0, READY=0 during reset then 1.
  - Required: repeating the impulse test gives the identical sequence.

Source files
------------

// File: rtl/fir_fold_sched.sv
// Folded 9-tap FIR: one shared 11x11 multiplier and a 26-bit accumulator, one tap per clock.
// A 9-entry circular sample buffer replaces the delay line; VIN/READY gates one sample per 10 cycles.
module fir_fold_sched (
    input  logic               CLK,
    input  logic               RST_n,
    input  logic signed [10:0] DIN,
    input  logic               VIN,
    output logic               READY,
    input  logic signed [10:0] H0,
    input  logic signed [10:0] H1,
    input  logic signed [10:0] H2,
    input  logic signed [10:0] H3,
    input  logic signed [10:0] H4,
    input  logic signed [10:0] H5,
    input  logic signed [10:0] H6,
    input  logic signed [10:0] H7,
    input  logic signed [10:0] H8,
    output logic signed [10:0] DOUT,
    output logic               VOUT
);

    typedef enum logic {StIdle, StMac} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_ready;
    logic               w_ready_nxt;
    logic               r_vout;
    logic signed [10:0] r_dout;
    logic signed [10:0] r_buf [9];
    logic signed [10:0] r_hs  [9];
    logic signed [10:0] w_h   [9];
    logic [3:0]         r_wptr;
    logic [3:0]         r_newest;
    logic [3:0]         r_tap;
    logic [3:0]         w_idx;
    logic signed [25:0] r_acc;
    logic signed [25:0] w_sum;
    logic signed [21:0] w_prod;
    logic signed [21:0] w_opa;
    logic signed [21:0] w_opb;
    logic               w_accept;
    logic               w_last;

    assign w_h[0] = H0;
    assign w_h[1] = H1;
    assign w_h[2] = H2;
    assign w_h[3] = H3;
    assign w_h[4] = H4;
    assign w_h[5] = H5;
    assign w_h[6] = H6;
    assign w_h[7] = H7;
    assign w_h[8] = H8;

    // Tap k reads the sample k positions older than the newest, modulo 9.
    assign w_idx  = (r_newest >= r_tap) ? (r_newest - r_tap) : (r_newest + 4'd9 - r_tap);
    assign w_opa  = {{11{r_hs[r_tap][10]}}, r_hs[r_tap]};
    assign w_opb  = {{11{r_buf[w_idx][10]}}, r_buf[w_idx]};
    assign w_prod = w_opa * w_opb;
    assign w_sum  = r_acc + {{4{w_prod[21]}}, w_prod};

    always_comb begin
        w_state_nxt = r_state;
        w_ready_nxt = r_ready;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        unique case (r_state)
            StIdle: begin
                w_accept = VIN & r_ready;
                if (w_accept) begin
                    w_state_nxt = StMac;
                    w_ready_nxt = 1'b0;
                end else begin
                    w_ready_nxt = 1'b1;
                end
            end
            StMac: begin
                if (r_tap == 4'd8) begin
                    w_last      = 1'b1;
                    w_state_nxt = StIdle;
                    w_ready_nxt = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            r_state  <= StIdle;
            r_ready  <= 1'b0;
            r_vout   <= 1'b0;
            r_dout   <= '0;
            r_wptr   <= '0;
            r_newest <= '0;
            r_tap    <= '0;
            r_acc    <= '0;
            for (int i = 0; i < 9; i++) begin
                r_buf[i] <= '0;
                r_hs[i]  <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            r_ready <= w_ready_nxt;
            r_vout  <= w_last;
            if (w_accept) begin
                r_buf[r_wptr] <= DIN;
                r_newest      <= r_wptr;
                r_wptr        <= (r_wptr == 4'd8) ? 4'd0 : r_wptr + 4'd1;
                r_hs          <= w_h;
                r_acc         <= '0;
                r_tap         <= '0;
            end else if (r_state == StMac) begin
                r_acc <= w_sum;
                if (w_last) begin
                    r_tap  <= '0;
                    // Floor by 2^10 and wrap to 11 bits, no rounding or saturation.
                    r_dout <= w_sum[20:10];
                end else begin
                    r_tap <= r_tap + 4'd1;
                end
            end
        end
    end

    assign READY = r_ready;
    assign VOUT  = r_vout;
    assign DOUT  = r_dout;

endmodule

// File: tb/tb_fir_fold_sched.sv
// Self-checking bench for fir_fold_sched: directed scenarios plus randomized traffic
// compared against a convolution model over the accepted-sample history.
module tb_fir_fold_sched;

    logic               clk;
    logic               rst_n;
    logic signed [10:0] din;
    logic               vin;
    logic               ready;
    logic signed [10:0] hc [9];
    logic signed [10:0] dout;
    logic               vout;

    int n_checks;
    int n_errors;
    int hist[$];
    int prev_exp;

    fir_fold_sched dut (
        .CLK   (clk),
        .RST_n (rst_n),
        .DIN   (din),
        .VIN   (vin),
        .READY (ready),
        .H0    (hc[0]),
        .H1    (hc[1]),
        .H2    (hc[2]),
        .H3    (hc[3]),
        .H4    (hc[4]),
        .H5    (hc[5]),
        .H6    (hc[6]),
        .H7    (hc[7]),
        .H8    (hc[8]),
        .DOUT  (dout),
        .VOUT  (vout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // y = floor(sum_k H[k] * x[n-k] / 1024), wrapped to 11 signed bits.
    function automatic int model();
        longint      s;
        logic [10:0] w;
        s = 0;
        for (int k = 0; k < 9; k++)
            if (k < hist.size()) s += longint'(hc[k]) * longint'(hist[k]);
        s = s >>> 10;
        w = s[10:0];
        return int'($signed(w));
    endfunction

    function automatic int dout_i();
        return int'(dout);
    endfunction

    task automatic set_impulse_coefs();
        for (int k = 0; k < 9; k++) hc[k] = 11'(64 * (k + 1));
    endtask

    // Present one sample, follow it through its MAC run, check its output.
    task automatic send(input int d, input bit keep, input int chg, input int rst_at,
                        input bit noise, output int got, output int waited);
        int ready_hi;
        int vout_early;
        int hold_bad;
        int exp;
        got      = 0;
        waited   = 0;
        din      = 11'(d);
        vin      = 1'b1;
        while (!ready && waited < 40) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!ready) begin
            chk("ready_timeout", 0, 1);
            vin = 1'b0;
            return;
        end
        @(posedge clk); #1;
        hist.push_front(d);
        if (hist.size() > 9) void'(hist.pop_back());
        exp        = model();
        vin        = keep;
        ready_hi   = 0;
        vout_early = 0;
        hold_bad   = 0;
        for (int i = 1; i <= 9; i++) begin
            if (noise) begin
                vin = 1'($urandom);
                din = 11'($urandom);
            end
            if (i == rst_at) begin
                rst_n = 1'b0;
                vin   = 1'b1;
            end
            @(posedge clk); #1;
            if (i == rst_at) begin
                rst_n = 1'b1;
                vin   = 1'b0;
                hist.delete();
                prev_exp = 0;
                chk("rst_mid_dout", dout_i(), 0);
                chk("rst_mid_vout", int'(vout), 0);
                chk("rst_mid_ready", int'(ready), 0);
                @(posedge clk); #1;
                chk("rst_mid_ready_rise", int'(ready), 1);
                vout_early = 0;
                for (int j = 0; j < 10; j++) begin
                    if (vout) vout_early++;
                    @(posedge clk); #1;
                end
                chk("rst_mid_no_vout", vout_early, 0);
                return;
            end
            if (i == chg) for (int k = 0; k < 9; k++) hc[k] = '0;
            if (i < 9) begin
                if (ready) ready_hi++;
                if (vout) vout_early++;
                if (dout_i() != prev_exp) hold_bad++;
            end
        end
        vin = keep;
        chk("busy_ready_low", ready_hi, 0);
        chk("busy_no_vout", vout_early, 0);
        chk("dout_hold", hold_bad, 0);
        chk("vout_pulse", int'(vout), 1);
        chk("ready_at_e9", int'(ready), 1);
        got = dout_i();
        chk("dout_model", got, exp);
        prev_exp = exp;
    endtask

    initial begin
        int got;
        int waited;
        int imp_exp [10];
        int d;
        bit keep;
        n_checks = 0;
        n_errors = 0;
        prev_exp = 0;
        for (int k = 0; k < 9; k++) hc[k] = '0;

        // Reset with VIN asserted: reset wins, no sample stored.
        rst_n = 1'b0;
        vin   = 1'b1;
        din   = 11'sd500;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dout", dout_i(), 0);
        chk("rst_vout", int'(vout), 0);
        chk("rst_ready", int'(ready), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_release_ready", int'(ready), 1);
        chk("rst_release_vout", int'(vout), 0);
        vin = 1'b0;

        for (int r = 0; r < 2; r++) begin
            set_impulse_coefs();
            for (int k = 0; k < 10; k++) imp_exp[k] = (k < 9) ? (64 * (k + 1) - 1) : 0;
            for (int k = 0; k < 10; k++) begin
                send((k == 0) ? 1023 : 0, 1'b0, -1, -1, 1'b0, got, waited);
                chk("impulse_const", got, imp_exp[k]);
            end
            if (r == 0) begin
                // Sign/floor after nine zeros have flushed the window.
                for (int k = 0; k < 9; k++) hc[k] = '0;
                hc[0] = 11'sd1023;
                send(-1024, 1'b0, -1, -1, 1'b0, got, waited);
                chk("sign_neg", got, -1023);
                send(1, 1'b0, -1, -1, 1'b0, got, waited);
                chk("floor_pos", got, 0);

                // Wrap with back-to-back accepts.
                for (int k = 0; k < 9; k++) hc[k] = 11'sd1023;
                for (int k = 0; k < 12; k++) begin
                    send(1023, (k < 11), -1, -1, 1'b0, got, waited);
                    chk("b2b_wait", waited, 0);
                    if (k >= 8) chk("wrap_const", got, 1006);
                end

                // Coefficient change mid-run applies only from the next accept.
                for (int k = 0; k < 9; k++) hc[k] = 11'($urandom);
                send(int'($signed(11'($urandom))), 1'b0, 3, -1, 1'b0, got, waited);
                send(int'($signed(11'($urandom))), 1'b0, -1, -1, 1'b0, got, waited);
                chk("coef_zero_next", got, 0);

                // Reset at E5 aborts the run; the impulse replay must match.
                set_impulse_coefs();
                send(777, 1'b0, -1, 5, 1'b0, got, waited);
            end
        end

        // Randomized traffic with ignored VIN noise during busy cycles.
        keep = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (n % 5 == 0 && !keep)
                for (int k = 0; k < 9; k++) hc[k] = 11'($urandom);
            d    = int'($signed(11'($urandom)));
            keep = (n < 39) ? 1'($urandom) : 1'b0;
            send(d, keep, -1, -1, !keep, got, waited);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
